dunit_exm_dumper: RTL and testbench

- Debug-unit reader for the EX/M pipeline latch.
- While the pipeline is frozen (debug clock enable low), it snapshots the EX/M latch outputs on request.
- It then streams them as a fixed 17-byte frame to the debug UART transmitter, using a byte-level start/done handshake.
- Sits between the EX/M latch outputs and the debug unit's UART TX.

---
 rtl/dunit_exm_dumper_pkg.sv | 24 ++
 rtl/dunit_frame_mux.sv | 53 +++++
 rtl/dunit_exm_dumper.sv | 123 ++++++++++++
 tb/tb_dunit_exm_dumper.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/dunit_exm_dumper_pkg.sv
// Shared debug-unit definitions for the pipeline latch dumpers: FSM state
// encoding, frame geometry and the default frame-start byte.
package dunit_exm_dumper_pkg;

    // Dumper FSM state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // EX/M frame geometry: byte offsets of each field, checksum last.
    localparam int FRAME_LEN  = 17;
    localparam int OFF_HEADER = 0;
    localparam int OFF_PC     = 1;
    localparam int OFF_ALU    = 5;
    localparam int OFF_WDATA  = 9;
    localparam int OFF_ADDR   = 13;
    localparam int OFF_CTRL   = 14;
    localparam int OFF_CSUM   = 16;

    // Default frame-start marker.
    localparam logic [7:0] HEADER_DEFAULT = 8'hE4;

endpackage

// File: rtl/dunit_frame_mux.sv
// Combinational frame byte selector: maps a frame index onto the snapshot
// fields (MSB-first within each field) or the running checksum.
module dunit_frame_mux
    import dunit_exm_dumper_pkg::*;
#(
    parameter int         NB_REG  = 32,
    parameter int         NB_CTRL = 9,
    parameter int         NB_ADDR = 5,
    parameter int         NB_BYTE = 8,
    parameter logic [7:0] HEADER  = HEADER_DEFAULT
) (
    input  logic [4:0]         idx,
    input  logic [NB_REG-1:0]  pc_eight,
    input  logic [NB_REG-1:0]  alu_result,
    input  logic [NB_REG-1:0]  w_data,
    input  logic [NB_ADDR-1:0] data_addr,
    input  logic [NB_CTRL-1:0] control,
    input  logic [NB_BYTE-1:0] checksum,
    output logic [NB_BYTE-1:0] frame_byte
);

    logic [7:0]  addr_ext;
    logic [15:0] ctrl_ext;
    logic [7:0]  fb [FRAME_LEN];

    // Zero-extend the narrow fields and lay out the whole frame as bytes.
    always_comb begin
        addr_ext = '0;
        addr_ext[NB_ADDR-1:0] = data_addr;
        ctrl_ext = '0;
        ctrl_ext[NB_CTRL-1:0] = control;
        for (int k = 0; k < FRAME_LEN; k++) fb[k] = 8'h00;
        fb[OFF_HEADER] = HEADER;
        for (int k = 0; k < 4; k++) begin
            fb[OFF_PC + k]    = pc_eight[31 - 8*k -: 8];
            fb[OFF_ALU + k]   = alu_result[31 - 8*k -: 8];
            fb[OFF_WDATA + k] = w_data[31 - 8*k -: 8];
        end
        fb[OFF_ADDR]     = addr_ext;
        fb[OFF_CTRL]     = ctrl_ext[15:8];
        fb[OFF_CTRL + 1] = ctrl_ext[7:0];
        fb[OFF_CSUM]     = checksum;
    end

    // Select the requested byte; indices past the frame read as zero.
    always_comb begin
        frame_byte = '0;
        for (int k = 0; k < FRAME_LEN; k++) begin
            if (idx == 5'(k)) frame_byte = fb[k];
        end
    end

endmodule

// File: rtl/dunit_exm_dumper.sv
// EX/M latch dumper: snapshots the latch on request and streams it as a
// 17-byte frame to the debug UART TX, one byte per start/done handshake.
//
// Handshake: o_tx_start is a one-cycle pulse in the SEND cycle with
// o_tx_data already valid; o_tx_data then holds until the next SEND. The
// transmitter answers with a one-cycle i_tx_done, honoured only in WAIT.
module dunit_exm_dumper
    import dunit_exm_dumper_pkg::*;
#(
    parameter int         NB_REG  = 32,
    parameter int         NB_CTRL = 9,
    parameter int         NB_ADDR = 5,
    parameter int         NB_BYTE = 8,
    parameter logic [7:0] HEADER  = HEADER_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_dump_req,
    input  logic [NB_REG-1:0]  i_pc_eight,
    input  logic [NB_REG-1:0]  i_alu_result,
    input  logic [NB_REG-1:0]  i_w_data,
    input  logic [NB_ADDR-1:0] i_data_addr,
    input  logic [NB_CTRL-1:0] i_control,
    input  logic               i_tx_done,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_done,
    output logic [1:0]         o_state
);

    logic [1:0]         state;
    logic [4:0]         index;
    logic [NB_BYTE-1:0] checksum;
    logic [NB_REG-1:0]  snap_pc;
    logic [NB_REG-1:0]  snap_alu;
    logic [NB_REG-1:0]  snap_wdata;
    logic [NB_ADDR-1:0] snap_addr;
    logic [NB_CTRL-1:0] snap_ctrl;
    logic [4:0]         next_index;
    logic [NB_BYTE-1:0] next_byte;

    // The byte for the following SEND is fetched while still in WAIT.
    assign next_index = index + 5'd1;

    dunit_frame_mux #(
        .NB_REG  (NB_REG),
        .NB_CTRL (NB_CTRL),
        .NB_ADDR (NB_ADDR),
        .NB_BYTE (NB_BYTE),
        .HEADER  (HEADER)
    ) u_frame_mux (
        .idx        (next_index),
        .pc_eight   (snap_pc),
        .alu_result (snap_alu),
        .w_data     (snap_wdata),
        .data_addr  (snap_addr),
        .control    (snap_ctrl),
        .checksum   (checksum),
        .frame_byte (next_byte)
    );

    // Frame sequencer: snapshot, per-byte start/done handshake, checksum.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state      <= ST_IDLE;
            index      <= '0;
            checksum   <= '0;
            snap_pc    <= '0;
            snap_alu   <= '0;
            snap_wdata <= '0;
            snap_addr  <= '0;
            snap_ctrl  <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            o_done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_dump_req) begin
                        snap_pc    <= i_pc_eight;
                        snap_alu   <= i_alu_result;
                        snap_wdata <= i_w_data;
                        snap_addr  <= i_data_addr;
                        snap_ctrl  <= i_control;
                        index      <= '0;
                        checksum   <= '0;
                        o_tx_data  <= HEADER;
                        o_tx_start <= 1'b1;
                        state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // The checksum byte itself is not folded into the checksum.
                    if (index < 5'd16) checksum <= checksum ^ o_tx_data;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_tx_done) begin
                        if (index == 5'd16) begin
                            o_done <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            index      <= next_index;
                            o_tx_data  <= next_byte;
                            o_tx_start <= 1'b1;
                            state      <= ST_SEND;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy  = (state != ST_IDLE);
    assign o_state = state;

endmodule

// File: tb/tb_dunit_exm_dumper.sv
// Directed bench for the EX/M latch dumper: a UART TX stand-in answers each
// start pulse with a done pulse three cycles later, and every frame byte is
// compared against hand-computed values.
module tb_dunit_exm_dumper;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_dump_req = 1'b0;
    logic [31:0] i_pc_eight = '0;
    logic [31:0] i_alu_result = '0;
    logic [31:0] i_w_data = '0;
    logic [4:0]  i_data_addr = '0;
    logic [8:0]  i_control = '0;
    logic        i_tx_done = 1'b0;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        o_busy;
    logic        o_done;
    logic [1:0]  o_state;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int done_cnt = 0;
    int s_mark;

    logic [7:0] exp_frame [17];

    dunit_exm_dumper dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_dump_req   (i_dump_req),
        .i_pc_eight   (i_pc_eight),
        .i_alu_result (i_alu_result),
        .i_w_data     (i_w_data),
        .i_data_addr  (i_data_addr),
        .i_control    (i_control),
        .i_tx_done    (i_tx_done),
        .o_tx_data    (o_tx_data),
        .o_tx_start   (o_tx_start),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_state      (o_state)
    );

    // clock / event counters
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (o_tx_start) start_cnt <= start_cnt + 1;
        if (o_done)     done_cnt  <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_tx_data"}, o_tx_data, 8'h00);
        chk({tag, "_tx_start"}, o_tx_start, 1'b0);
        chk({tag, "_busy"}, o_busy, 1'b0);
        chk({tag, "_done"}, o_done, 1'b0);
        chk({tag, "_state"}, o_state, 2'd0);
    endtask

    // mode 0 plain, 1 inputs change after accept, 2 extra requests in WAIT
    // of byte 5 and in DONE, 3 stray done in SEND of byte 3, 4 reset in WAIT
    // of byte 9 (frame abandoned)
    task automatic run_frame(input int mode, input logic [31:0] pc, input logic [31:0] alu,
                             input logic [31:0] wd, input logic [4:0] addr, input logic [8:0] ctrl);
        int  s0;
        int  d0;
        int  waited;
        logic found;
        s0 = start_cnt;
        d0 = done_cnt;
        i_pc_eight = pc; i_alu_result = alu; i_w_data = wd;
        i_data_addr = addr; i_control = ctrl;
        i_dump_req = 1'b1;
        tick();
        i_dump_req = 1'b0;
        if (mode == 1) begin
            i_pc_eight = 32'hFFFF_FFFF; i_alu_result = 32'hFFFF_FFFF;
            i_w_data = 32'hFFFF_FFFF; i_data_addr = 5'h1F; i_control = 9'h1FF;
        end
        for (int b = 0; b < 17; b++) begin
            found = 1'b0;
            waited = 0;
            for (int w = 0; w < 20 && !found; w++) begin
                if (o_tx_start) found = 1'b1;
                else begin tick(); waited++; end
            end
            chk($sformatf("start_seen_b%0d", b), found, 1'b1);
            if (!found) return;
            if (b == 0) chk("first_start_latency", waited, 0);
            chk($sformatf("byte%0d", b), o_tx_data, exp_frame[b]);
            chk($sformatf("busy_b%0d", b), o_busy, 1'b1);
            if (mode == 3 && b == 3) begin
                i_tx_done = 1'b1;
                tick();
                i_tx_done = 1'b0;
                chk("stray_done_no_start", o_tx_start, 1'b0);
                chk("stray_done_state_wait", o_state, 2'd2);
                chk("stray_done_data_held", o_tx_data, exp_frame[3]);
            end else begin
                tick();
            end
            if (mode == 4 && b == 9) begin
                i_reset = 1'b0;
                #1;
                chk_quiet("async_reset");
                return;
            end
            chk($sformatf("wait_start_low_b%0d", b), o_tx_start, 1'b0);
            if (mode == 2 && b == 5) begin
                i_dump_req = 1'b1;
                tick();
                i_dump_req = 1'b0;
            end else begin
                tick();
            end
            tick();
            i_tx_done = 1'b1;
            tick();
            i_tx_done = 1'b0;
        end
        chk("done_pulse", o_done, 1'b1);
        chk("done_busy", o_busy, 1'b1);
        chk("done_state", o_state, 2'd3);
        if (mode == 2) i_dump_req = 1'b1;
        tick();
        i_dump_req = 1'b0;
        chk("done_one_cycle", o_done, 1'b0);
        chk("busy_low_after_done", o_busy, 1'b0);
        repeat (5) tick();
        chk("frame_start_count", start_cnt - s0, 17);
        chk("frame_done_count", done_cnt - d0, 1);
        chk("idle_after_frame", o_state, 2'd0);
    endtask

    initial begin
        // reset and idle
        repeat (3) tick();
        chk_quiet("in_reset");
        i_reset = 1'b1;
        repeat (10) tick();
        chk_quiet("idle10");
        chk("idle_no_starts", start_cnt, 0);

        // pc=8, addr=1F, control=1FF: checksum E4^08^1F^01^FF = 0D
        exp_frame = '{8'hE4, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00,
                      8'h00, 8'h00, 8'h00, 8'h00, 8'h1F, 8'h01, 8'hFF, 8'h0D};
        run_frame(0, 32'h0000_0008, 32'h0, 32'h0, 5'h1F, 9'h1FF);
        run_frame(1, 32'h0000_0008, 32'h0, 32'h0, 5'h1F, 9'h1FF);
        run_frame(2, 32'h0000_0008, 32'h0, 32'h0, 5'h1F, 9'h1FF);

        // stray done while idle
        s_mark = start_cnt;
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        tick();
        chk("idle_stray_done_state", o_state, 2'd0);
        chk("idle_stray_done_busy", o_busy, 1'b0);
        chk("idle_stray_done_starts", start_cnt - s_mark, 0);

        run_frame(3, 32'h0000_0008, 32'h0, 32'h0, 5'h1F, 9'h1FF);

        // checksum E4^12^34^56^78^(A5 x4)^(0F x4)^03^00^AB = 44
        exp_frame = '{8'hE4, 8'h12, 8'h34, 8'h56, 8'h78, 8'hA5, 8'hA5, 8'hA5, 8'hA5,
                      8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h03, 8'h00, 8'hAB, 8'h44};
        run_frame(4, 32'h1234_5678, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 5'h03, 9'h0AB);
        tick();
        tick();
        chk_quiet("held_reset");
        i_reset = 1'b1;
        s_mark = start_cnt;
        repeat (5) tick();
        chk("post_reset_no_starts", start_cnt - s_mark, 0);
        chk("post_reset_idle", o_busy, 1'b0);
        run_frame(0, 32'h1234_5678, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 5'h03, 9'h0AB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
